// File: rtl/alu_pkg.sv
// ----------------------------------------------------------------------------
// alu_pkg : shared ALU widths and add/sub operation encoding.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package alu_pkg;

  localparam int ALU_WIDTH_DEFAULT = 32;
  localparam int ALU_BLOCK_DEFAULT = 8;

  typedef enum logic {
    OP_ADD = 1'b0,
    OP_SUB = 1'b1
  } alu_op_e;

endpackage

`default_nettype wire

// File: rtl/cla_slice.sv
// ----------------------------------------------------------------------------
// cla_slice : combinational BLOCK-bit carry-lookahead slice.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module cla_slice
  import alu_pkg::*;
#(
  parameter int BLOCK = ALU_BLOCK_DEFAULT
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             c_msb,
  output logic             zero
);

  logic [BLOCK-1:0] g;
  logic [BLOCK-1:0] p;
  logic [BLOCK:0]   gc;
  logic [BLOCK:0]   c;

  // c[i+1] = OR over every generator at or below bit i (cin counts as the
  // generator at position 0), each ANDed with the propagates above it.
  always_comb begin
    logic term;
    logic acc;
    term = 1'b0;
    acc  = 1'b0;
    g    = a & b;
    p    = a | b;
    gc   = {g, cin};
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      acc = 1'b0;
      for (int j = 0; j <= i + 1; j++) begin
        term = gc[j];
        for (int k = j; k <= i; k++) begin
          term = term & p[k];
        end
        acc = acc | term;
      end
      c[i+1] = acc;
    end
    sum   = a ^ b ^ c[BLOCK-1:0];
    cout  = c[BLOCK];
    c_msb = c[BLOCK-1];
    zero  = ~|sum;
  end

endmodule

`default_nettype wire

// File: rtl/pipe_cla_addsub.sv
// ----------------------------------------------------------------------------
// pipe_cla_addsub : pipelined carry-lookahead add/sub, one slice per stage.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module pipe_cla_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH_DEFAULT,
  parameter int BLOCK = ALU_BLOCK_DEFAULT
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  input  logic             in_sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int STAGES = WIDTH / BLOCK;

  logic adv;

  // Stage k registers hold the result of slice k; the last stage is the output.
  logic [WIDTH-1:0] r_a    [STAGES];
  logic [WIDTH-1:0] r_b    [STAGES];
  logic [WIDTH-1:0] r_sum  [STAGES];
  logic             r_vld  [STAGES];
  logic             r_cy   [STAGES];
  logic             r_zero [STAGES];
  logic             r_ovf;

  logic [WIDTH-1:0] w_opa    [STAGES];
  logic [WIDTH-1:0] w_opb    [STAGES];
  logic [WIDTH-1:0] w_sum_in [STAGES];
  logic             w_cin    [STAGES];
  logic             w_zin    [STAGES];
  logic             w_vin    [STAGES];

  logic [BLOCK-1:0] w_slsum   [STAGES];
  logic             w_slcout  [STAGES];
  logic             w_slcmsb  [STAGES];
  logic             w_slzero  [STAGES];

  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_opa[k]    = in_a;
      assign w_opb[k]    = (in_sub == OP_SUB) ? ~in_b : in_b;
      assign w_cin[k]    = (in_sub == OP_SUB) ? 1'b1 : in_cin;
      assign w_vin[k]    = in_valid;
      assign w_sum_in[k] = '0;
      assign w_zin[k]    = 1'b1;
    end else begin : g_body
      assign w_opa[k]    = r_a[k-1];
      assign w_opb[k]    = r_b[k-1];
      assign w_cin[k]    = r_cy[k-1];
      assign w_vin[k]    = r_vld[k-1];
      assign w_sum_in[k] = r_sum[k-1];
      assign w_zin[k]    = r_zero[k-1];
    end

    cla_slice #(
      .BLOCK(BLOCK)
    ) u_slice (
      .a     (w_opa[k][BLOCK-1:0]),
      .b     (w_opb[k][BLOCK-1:0]),
      .cin   (w_cin[k]),
      .sum   (w_slsum[k]),
      .cout  (w_slcout[k]),
      .c_msb (w_slcmsb[k]),
      .zero  (w_slzero[k])
    );
  end

  // Operands shift down one slice per stage so every stage reads bits [BLOCK-1:0].
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]  <= 1'b0;
        r_a[k]    <= '0;
        r_b[k]    <= '0;
        r_sum[k]  <= '0;
        r_cy[k]   <= 1'b0;
        r_zero[k] <= 1'b0;
      end
      r_ovf <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        r_vld[k]  <= w_vin[k];
        r_a[k]    <= w_opa[k] >> BLOCK;
        r_b[k]    <= w_opb[k] >> BLOCK;
        r_sum[k]  <= w_sum_in[k] | (WIDTH'(w_slsum[k]) << (k * BLOCK));
        r_cy[k]   <= w_slcout[k];
        r_zero[k] <= w_zin[k] & w_slzero[k];
      end
      r_ovf <= w_slcmsb[STAGES-1] ^ w_slcout[STAGES-1];
    end
  end

  assign out_valid = r_vld[STAGES-1];
  assign out_sum   = r_sum[STAGES-1];
  assign out_cout  = r_cy[STAGES-1];
  assign out_zero  = r_zero[STAGES-1];
  assign out_ovf   = r_ovf;

endmodule

`default_nettype wire

// File: tb/tb_pipe_cla_addsub.sv
// ----------------------------------------------------------------------------
// tb_pipe_cla_addsub : scoreboard bench for the pipelined add/sub.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_pipe_cla_addsub;

  localparam int W   = 32;
  localparam int LAT = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         in_cin = 1'b0;
  logic         in_sub = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_sum;
  logic         out_cout;
  logic         out_ovf;
  logic         out_zero;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
    int           cyc;
  } exp_t;

  exp_t q[$];
  bit   vhist[int];
  int   n_checks = 0;
  int   n_errors = 0;
  int   ncyc = 0;
  int   n_ret = 0;
  bit   lat_en = 1'b0;
  bit   pat_en = 1'b0;
  bit   rnd_rdy = 1'b0;
  bit   prev_stall = 1'b0;

  pipe_cla_addsub #(
    .WIDTH(W),
    .BLOCK(8)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_sub    (in_sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain WIDTH+1-bit arithmetic on the effective operands.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic cin, input logic sub, input int cyc);
    exp_t       e;
    logic [W-1:0] bb;
    logic [W:0]   full;
    bb     = sub ? ~b : b;
    full   = (W+1)'(a) + (W+1)'(bb) + (W+1)'(sub ? 1'b1 : cin);
    e.sum  = full[W-1:0];
    e.cout = full[W];
    e.zero = (e.sum == '0);
    e.ovf  = (a[W-1] == bb[W-1]) && (e.sum[W-1] != a[W-1]);
    e.cyc  = cyc;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t head;
    if (reset) begin
      prev_stall = 1'b0;
    end else begin
      ncyc++;
      if (prev_stall) check_val("hold_valid", 64'(out_valid), 64'd1);
      if (pat_en && vhist.exists(ncyc - LAT))
        check_val("bubble_pattern", 64'(out_valid), 64'(vhist[ncyc - LAT]));
      if (pat_en) vhist[ncyc] = in_valid;
      if (out_valid) begin
        if (q.size() == 0) begin
          check_val("extra_result", 64'(out_valid), 64'd0);
        end else begin
          head = q[0];
          check_val("sum",  64'(out_sum),  64'(head.sum));
          check_val("cout", 64'(out_cout), 64'(head.cout));
          check_val("ovf",  64'(out_ovf),  64'(head.ovf));
          check_val("zero", 64'(out_zero), 64'(head.zero));
          if (out_ready) begin
            void'(q.pop_front());
            n_ret++;
            if (lat_en) check_val("latency", 64'(ncyc - head.cyc), 64'(LAT));
          end
        end
      end
      if (in_valid && in_ready) q.push_back(model(in_a, in_b, in_cin, in_sub, ncyc));
      prev_stall = out_valid && !out_ready;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
    if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
    int   n;
    logic acc;
    n = 0;
    acc = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    in_sub = sub;
    while (!acc && n < 200) begin
      @(negedge clock);
      acc = in_ready;
      tick();
      n++;
    end
    if (!acc) check_val("send_timeout", 64'(acc), 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    check_val("drain", 64'(q.size()), 64'd0);
  endtask

  function automatic logic [W-1:0] rnd_word();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h7FFF_FFFF;
      3:       return 32'h8000_0000;
      default: return 32'($urandom);
    endcase
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int op;
    int base;
    repeat (3) @(posedge clock);
    #1;
    check_val("rst_valid", 64'(out_valid), 64'd0);
    check_val("rst_sum",   64'(out_sum),   64'd0);
    check_val("rst_cout",  64'(out_cout),  64'd0);
    check_val("rst_ovf",   64'(out_ovf),   64'd0);
    check_val("rst_zero",  64'(out_zero),  64'd0);
    check_val("rst_ready", 64'(in_ready),  64'd1);
    reset = 1'b0;
    tick();

    // Carry ripple, subtract with/without borrow, signed overflow.
    lat_en = 1'b1;
    send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1);
    send(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1);
    send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
    send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
    send(32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1);
    wait_empty();

    // Backpressure: out_ready low on cycles 5..7 of a 6-op stream.
    lat_en = 1'b0;
    base = n_ret;
    op = 1;
    for (int c = 1; c <= 14; c++) begin
      out_ready = !(c >= 5 && c <= 7);
      in_valid  = (op <= 6);
      in_a      = 32'(op);
      in_b      = 32'(op * 32'h100);
      in_cin    = 1'b0;
      in_sub    = 1'b0;
      @(negedge clock);
      check_val("bp_in_ready", 64'(in_ready), 64'(!(c >= 5 && c <= 7)));
      if (in_valid && in_ready) op++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    wait_empty();
    check_val("bp_count", 64'(n_ret - base), 64'd6);

    // Bubbles with carry-in.
    lat_en = 1'b1;
    vhist.delete();
    pat_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = (i % 2 == 0);
      in_a = 32'h0000_00FF;
      in_b = 32'h0000_0000;
      in_cin = 1'b1;
      in_sub = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    repeat (6) tick();
    pat_en = 1'b0;
    wait_empty();

    // Asynchronous reset with three ops in flight.
    send(32'h0000_0011, 32'h0000_0022, 1'b0, 1'b0);
    send(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    send(32'h0000_0003, 32'h0000_0009, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check_val("mid_rst_valid", 64'(out_valid), 64'd0);
    check_val("mid_rst_sum",   64'(out_sum),   64'd0);
    check_val("mid_rst_cout",  64'(out_cout),  64'd0);
    check_val("mid_rst_ovf",   64'(out_ovf),   64'd0);
    check_val("mid_rst_zero",  64'(out_zero),  64'd0);
    q.delete();
    @(posedge clock);
    #3;
    reset = 1'b0;
    repeat (8) tick();
    send(32'h0000_0100, 32'h0000_0023, 1'b1, 1'b0);
    wait_empty();

    // Randomized traffic with random backpressure and input gaps.
    lat_en = 1'b0;
    rnd_rdy = 1'b1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick();
      send(rnd_word(), rnd_word(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    rnd_rdy = 1'b0;
    out_ready = 1'b1;
    wait_empty();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
